// File: rtl/fifo_mem_prog_if.sv
// Handshake/status bundle for fifo_mem_prog: the master side drives writes, pops and
// error clears; the slave side (the FIFO) returns read data, occupancy and flags.
interface fifo_mem_prog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  par_inj;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
  logic                  parity_err;

  modport master (
    output wr_en, wr_data, par_inj, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow, parity_err
  );

  modport slave (
    input  wr_en, wr_data, par_inj, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow, parity_err
  );
endinterface

// File: rtl/fifo_mem_prog.sv
// Synchronous FIFO with fill level, almost flags, FWFT option and sticky error flags.
// Define FIFO_MEM_PARITY_EN to store and check an even-parity bit per entry.
module fifo_mem_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input logic           clk,
  input logic           rst_n,
  fifo_mem_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef FIFO_MEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          full_w;
  logic          empty_w;
  logic          rd_acc;
  logic          wr_acc;
  logic          overflow_q;
  logic          underflow_q;
  logic [MW-1:0] wr_entry;
  logic [MW-1:0] head;

  assign full_w  = (level_q == FULL_LVL);
  assign empty_w = (level_q == '0);

  // A pop frees the slot, so a write into a full FIFO may proceed alongside it.
  assign rd_acc = bus.rd_en & ~empty_w;
  assign wr_acc = bus.wr_en & (~full_w | rd_acc);
  assign head   = mem[rd_ptr];

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (level_q >= AF_LVL);
  assign bus.almost_empty = (level_q <= AE_LVL);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

`ifdef FIFO_MEM_PARITY_EN
  logic parity_q;

  assign wr_entry       = {(^bus.wr_data) ^ bus.par_inj, bus.wr_data};
  assign bus.parity_err = parity_q;

  // Even parity over data plus stored bit must reduce to zero for a clean word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= (parity_q & ~bus.clr_err) | (rd_acc & (^head));
    end
  end
`else
  logic unused_par_inj;

  assign unused_par_inj = bus.par_inj;
  assign wr_entry       = bus.wr_data;
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // A new error event in the clearing cycle keeps its flag set.
      overflow_q  <= (overflow_q & ~bus.clr_err) | (bus.wr_en & ~wr_acc);
      underflow_q <= (underflow_q & ~bus.clr_err) | (bus.rd_en & empty_w);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = empty_w ? '0 : head[DATA_WIDTH-1:0];
      assign bus.rd_valid = ~empty_w;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= head[DATA_WIDTH-1:0];
          end
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_mem_prog.sv
// Drives identical traffic into a registered-read and an FWFT instance of fifo_mem_prog
// and compares both against a queue-based model of the FIFO rules.
module tb_fifo_mem_prog;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          inj;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_mem_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  fifo_mem_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  entry_t        q[$];
  logic [DW-1:0] exp_rd_data0;
  logic          exp_rd_valid0;
  logic          exp_ovf;
  logic          exp_unf;
  logic          exp_par;
  int            total = 0;
  int            bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkBus(input string name, input bit fwft, input logic [LW-1:0] lvl,
                          input logic f, input logic e, input logic af, input logic ae,
                          input logic ov, input logic un, input logic pe,
                          input logic [DW-1:0] rd, input logic rv);
    int n = q.size();
    checkOutput({name, ".level"}, 32'(lvl), 32'(n));
    checkOutput({name, ".full"}, 32'(f), 32'(n == DEPTH));
    checkOutput({name, ".empty"}, 32'(e), 32'(n == 0));
    checkOutput({name, ".almost_full"}, 32'(af), 32'(n >= AF));
    checkOutput({name, ".almost_empty"}, 32'(ae), 32'(n <= AE));
    checkOutput({name, ".overflow"}, 32'(ov), 32'(exp_ovf));
    checkOutput({name, ".underflow"}, 32'(un), 32'(exp_unf));
    checkOutput({name, ".parity_err"}, 32'(pe), 32'(exp_par));
    if (fwft) begin
      checkOutput({name, ".rd_valid"}, 32'(rv), 32'(n != 0));
      if (n != 0) checkOutput({name, ".rd_data"}, 32'(rd), 32'(q[0].data));
    end else begin
      checkOutput({name, ".rd_valid"}, 32'(rv), 32'(exp_rd_valid0));
      checkOutput({name, ".rd_data"}, 32'(rd), 32'(exp_rd_data0));
    end
  endtask

  task automatic checkAll();
    checkBus("reg", 1'b0, bus0.level, bus0.full, bus0.empty, bus0.almost_full,
             bus0.almost_empty, bus0.overflow, bus0.underflow, bus0.parity_err,
             bus0.rd_data, bus0.rd_valid);
    checkBus("fwft", 1'b1, bus1.level, bus1.full, bus1.empty, bus1.almost_full,
             bus1.almost_empty, bus1.overflow, bus1.underflow, bus1.parity_err,
             bus1.rd_data, bus1.rd_valid);
  endtask

  task automatic modelReset();
    q.delete();
    exp_rd_data0  = '0;
    exp_rd_valid0 = 1'b0;
    exp_ovf       = 1'b0;
    exp_unf       = 1'b0;
    exp_par       = 1'b0;
  endtask

  // One clock of traffic: drive both instances, step the model, check after the edge.
  task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re,
                               input logic ce, input logic pi);
    bit     rd_ok;
    bit     wr_ok;
    bit     par_evt;
    entry_t popped;
    bus0.wr_en = we; bus0.wr_data = wd; bus0.rd_en = re; bus0.clr_err = ce; bus0.par_inj = pi;
    bus1.wr_en = we; bus1.wr_data = wd; bus1.rd_en = re; bus1.clr_err = ce; bus1.par_inj = pi;
    @(posedge clk);
    rd_ok   = re && (q.size() != 0);
    wr_ok   = we && ((q.size() < DEPTH) || rd_ok);
    par_evt = 1'b0;
    exp_ovf = (exp_ovf && !ce) || (we && !wr_ok);
    exp_unf = (exp_unf && !ce) || (re && q.size() == 0);
    exp_rd_valid0 = rd_ok;
    if (rd_ok) begin
      popped       = q.pop_front();
      exp_rd_data0 = popped.data;
`ifdef FIFO_MEM_PARITY_EN
      par_evt      = popped.inj;
`endif
    end
    exp_par = (exp_par && !ce) || par_evt;
    if (wr_ok) q.push_back('{data: wd, inj: pi});
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus0.wr_en = 0; bus0.wr_data = '0; bus0.rd_en = 0; bus0.clr_err = 0; bus0.par_inj = 0;
    bus1.wr_en = 0; bus1.wr_data = '0; bus1.rd_en = 0; bus1.clr_err = 0; bus1.par_inj = 0;
    modelReset();
    #12;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill and drain with overflow");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0012, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    $display("[TB] underflow with simultaneous write");
    applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("[TB] fall-through visibility and parity injection");
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("[TB] shallow interleaved traffic across pointer wrap");
    for (int i = 0; i < 40; i++) begin
      logic we;
      logic re;
      we = (q.size() < 5) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      re = 1'($urandom_range(0, 1));
      applyStimulus(we, DW'($urandom), re, 1'b0, 1'b0);
    end
    while (q.size() > 3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    while (q.size() < 3) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset at level 3");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      logic we;
      logic re;
      we = 1'($urandom_range(0, 99) < 55);
      re = 1'($urandom_range(0, 99) < 50);
      applyStimulus(we, DW'($urandom), re, 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
